// File: rtl/spectrum_pkg.sv
// Shared types for the spectrum run reporter: run-tracker state,
// the report record layout and the record width helper.
package spectrum_pkg;

   // Widest bin/run field any instance may use; record fields are sized to it.
   localparam int MAX_BIN_W = 16;

   // Run tracker: either between runs or inside a run of exceeding bins.
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_RUN = 1'b1
   } run_state_e;

   // One report as seen by a consumer. Instances narrower than MAX_BIN_W
   // carry their start/length zero-extended in these fields.
   typedef struct packed {
      logic [7:0]           frame_id;
      logic [MAX_BIN_W-1:0] start_bin;
      logic [MAX_BIN_W-1:0] run_len;
      logic                 last;
   } report_rec_t;

   // Width of the packed {frame_id, start_bin, run_len} payload on m_tdata.
   function automatic int rec_width(input int bin_w);
      return 8 + 2 * bin_w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with two ordered write ports (port 0 is written first)
// and an occupancy count. The user must never write port 1 without port 0,
// never write more entries than are free, and never read when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr0_en,
   input  logic [WIDTH-1:0]           wr0_data,
   input  logic                       wr1_en,
   input  logic [WIDTH-1:0]           wr1_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr_nxt;
   logic [CW-1:0]    cnt_q;

   assign wr_ptr_nxt = wr_ptr + AW'(1);

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (wr0_en) mem[wr_ptr]     <= wr0_data;
      if (wr1_en) mem[wr_ptr_nxt] <= wr1_data;
   end

   // Pointers and occupancy; pushes and a pop may land on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         cnt_q  <= cnt_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;

endmodule

// File: rtl/run_reporter.sv
// Turns a per-bin threshold-exceed flag stream into run reports
// {frame_id, start_bin, run_len} plus one terminator record per frame.
//
// Both streams use AXI-style valid/ready: a beat transfers on a rising edge
// where valid && ready; a source holds valid and data until that edge;
// s_tready never depends on s_tvalid, m_tvalid never depends on m_tready.
module run_reporter
   import spectrum_pkg::*;
#(
   parameter int BIN_W      = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [7:0]                 s_tdata,
   input  logic                       s_tlast,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [rec_width(BIN_W)-1:0] m_tdata,
   output logic                       m_tlast,
   input  logic [BIN_W-1:0]           min_run,
   output logic [7:0]                 frame_cnt,
   output logic                       bin_ovf
);

   localparam int REC_W  = rec_width(BIN_W);
   localparam int WORD_W = REC_W + 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BIN_W-1:0] BIN_MAX = '1;

   run_state_e       state_q, state_d;
   logic [BIN_W-1:0] bin_idx_q;
   logic [BIN_W-1:0] run_start_q, run_start_d;
   logic [BIN_W-1:0] run_len_q, run_len_d;
   logic [BIN_W-1:0] min_run_q;
   logic [7:0]       frame_id_q;
   logic             bin_ovf_q;
   logic             frame_start_q;

   logic             beat;
   logic             flag;
   logic             closing;
   logic [BIN_W-1:0] close_start;
   logic [BIN_W-1:0] close_len;
   logic [BIN_W-1:0] min_eff;
   logic [BIN_W-1:0] min_thr;
   logic             push_close;
   logic             push_term;
   logic [WORD_W-1:0] close_word;
   logic [WORD_W-1:0] term_word;
   logic [WORD_W-1:0] head_word;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             pop;
   logic             unused_tdata;

   assign unused_tdata = ^s_tdata[7:1];
   assign beat = s_tvalid && s_tready;
   assign flag = s_tdata[0];

   // The first bin of a frame uses the live min_run; later bins use the copy.
   assign min_eff = frame_start_q ? min_run : min_run_q;
   assign min_thr = (min_eff == '0) ? BIN_W'(1) : min_eff;

   // Run tracking: step the run for this beat, then force-close on tlast.
   always_comb begin
      state_d     = state_q;
      run_start_d = run_start_q;
      run_len_d   = run_len_q;
      closing     = 1'b0;
      close_start = run_start_q;
      close_len   = run_len_q;
      if (beat) begin
         case (state_q)
            ST_IDLE: begin
               if (flag) begin
                  state_d     = ST_IN_RUN;
                  run_start_d = bin_idx_q;
                  run_len_d   = BIN_W'(1);
               end
            end
            ST_IN_RUN: begin
               if (flag) begin
                  run_len_d = (run_len_q == BIN_MAX) ? run_len_q : run_len_q + BIN_W'(1);
               end else begin
                  closing = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
         if (s_tlast && state_d == ST_IN_RUN) begin
            closing     = 1'b1;
            close_start = run_start_d;
            close_len   = run_len_d;
            state_d     = ST_IDLE;
         end
      end
   end

   assign push_close = closing && (close_len >= min_thr);
   assign push_term  = beat && s_tlast;
   assign close_word = {1'b0, frame_id_q, close_start, close_len};
   assign term_word  = {1'b1, frame_id_q, bin_idx_q + BIN_W'(1), {BIN_W{1'b0}}};

   // Run state, bin position, frame numbering and overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         run_start_q   <= '0;
         run_len_q     <= '0;
         bin_idx_q     <= '0;
         min_run_q     <= '0;
         frame_id_q    <= '0;
         bin_ovf_q     <= 1'b0;
         frame_start_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         run_start_q <= run_start_d;
         run_len_q   <= run_len_d;
         if (beat) begin
            if (frame_start_q) min_run_q <= min_run;
            frame_start_q <= s_tlast;
            if (s_tlast) begin
               bin_idx_q  <= '0;
               frame_id_q <= frame_id_q + 8'd1;
            end else begin
               bin_idx_q <= bin_idx_q + BIN_W'(1);
               if (bin_idx_q == BIN_MAX) bin_ovf_q <= 1'b1;
            end
         end
      end
   end

   // A closed run always precedes the frame terminator in the FIFO.
   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr0_en   (push_close || push_term),
      .wr0_data (push_close ? close_word : term_word),
      .wr1_en   (push_close && push_term),
      .wr1_data (term_word),
      .rd_en    (pop),
      .rd_data  (head_word),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Two free entries cover the worst beat: a run record plus a terminator.
   assign s_tready  = rst_n && (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
   assign m_tvalid  = !fifo_empty;
   assign pop       = m_tvalid && m_tready;
   assign m_tdata   = fifo_empty ? '0 : head_word[REC_W-1:0];
   assign m_tlast   = !fifo_empty && head_word[REC_W];
   assign frame_cnt = frame_id_q;
   assign bin_ovf   = bin_ovf_q;

endmodule

// File: tb/tb_run_reporter.sv
// Bench for run_reporter: a 12-bit instance (a_*) for the main function and
// a 4-bit instance (b_*) for bin wrap and length saturation.
module tb_run_reporter;
   import spectrum_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_m_tlast, a_bin_ovf;
   logic [7:0]  a_s_tdata, a_frame_cnt;
   logic [31:0] a_m_tdata;
   logic [11:0] a_min_run;

   logic        b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast, b_bin_ovf;
   logic [7:0]  b_s_tdata, b_frame_cnt;
   logic [15:0] b_m_tdata;
   logic [3:0]  b_min_run;

   run_reporter #(.BIN_W(12), .FIFO_DEPTH(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tdata(a_s_tdata), .s_tlast(a_s_tlast),
      .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tdata(a_m_tdata), .m_tlast(a_m_tlast),
      .min_run(a_min_run), .frame_cnt(a_frame_cnt), .bin_ovf(a_bin_ovf));

   run_reporter #(.BIN_W(4), .FIFO_DEPTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata), .s_tlast(b_s_tlast),
      .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast),
      .min_run(b_min_run), .frame_cnt(b_frame_cnt), .bin_ovf(b_bin_ovf));

   // ---------------- scoreboard state ----------------
   report_rec_t exp_a[$], act_a[$], exp_b[$], act_b[$];
   bit          frm_a[$], frm_b[$];
   int          fid_a = 0, fid_b = 0, mn_a = 0, mn_b = 0;
   int          total = 0, bad = 0;
   bit          rand_rdy = 1'b0;

   function automatic report_rec_t mk_rec(input bit last, input int fid, input int start, input int len);
      report_rec_t r;
      r.frame_id  = 8'(fid);
      r.start_bin = 16'(start);
      r.run_len   = 16'(len);
      r.last      = last;
      return r;
   endfunction

   // Reference model: find maximal runs of ones in a finished frame.
   task automatic model_frame(input int which);
      bit fl[$];
      int bw, n, i, len, start, mn, lim, modv, fid;
      report_rec_t r;
      if (which == 0) begin fl = frm_a; bw = 12; mn = mn_a; fid = fid_a; end
      else begin fl = frm_b; bw = 4; mn = mn_b; fid = fid_b; end
      lim = (1 << bw) - 1;
      modv = 1 << bw;
      n = fl.size();
      if (mn < 1) mn = 1;
      i = 0;
      while (i < n) begin
         if (fl[i]) begin
            start = i;
            len = 0;
            while (i < n && fl[i]) begin len++; i++; end
            if (len > lim) len = lim;
            if (len >= mn) begin
               r = mk_rec(1'b0, fid, start % modv, len);
               if (which == 0) exp_a.push_back(r); else exp_b.push_back(r);
            end
         end else begin
            i++;
         end
      end
      r = mk_rec(1'b1, fid, n % modv, 0);
      if (which == 0) begin exp_a.push_back(r); fid_a = (fid_a + 1) % 256; frm_a.delete(); end
      else begin exp_b.push_back(r); fid_b = (fid_b + 1) % 256; frm_b.delete(); end
   endtask

   // Monitors: capture accepted inputs into the model and popped reports.
   always @(negedge clk) begin
      if (!rst_n) begin
         frm_a.delete(); frm_b.delete();
         fid_a = 0; fid_b = 0;
      end else begin
         if (a_m_tvalid && a_m_tready)
            act_a.push_back(mk_rec(a_m_tlast, a_m_tdata[31:24], a_m_tdata[23:12], a_m_tdata[11:0]));
         if (b_m_tvalid && b_m_tready)
            act_b.push_back(mk_rec(b_m_tlast, b_m_tdata[15:8], b_m_tdata[7:4], b_m_tdata[3:0]));
         if (a_s_tvalid && a_s_tready) begin
            if (frm_a.size() == 0) mn_a = a_min_run;
            frm_a.push_back(a_s_tdata[0]);
            if (a_s_tlast) model_frame(0);
         end
         if (b_s_tvalid && b_s_tready) begin
            if (frm_b.size() == 0) mn_b = b_min_run;
            frm_b.push_back(b_s_tdata[0]);
            if (b_s_tlast) model_frame(1);
         end
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic cmp_int(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic cmp_rec(input string name, input report_rec_t got, input report_rec_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got {fid=%0d start=%0d len=%0d last=%0d} want {fid=%0d start=%0d len=%0d last=%0d}",
                  name, got.frame_id, got.start_bin, got.run_len, got.last,
                  want.frame_id, want.start_bin, want.run_len, want.last);
      end
   endtask

   // Drain one instance and compare every captured report with expectations.
   task automatic check_queue(input int which, input string name);
      int c;
      report_rec_t e, g;
      if (which == 0) a_m_tready = 1'b1; else b_m_tready = 1'b1;
      c = 0;
      while (c < 3000) begin
         @(negedge clk);
         if (which == 0 && !a_m_tvalid && act_a.size() >= exp_a.size()) break;
         if (which == 1 && !b_m_tvalid && act_b.size() >= exp_b.size()) break;
         c++;
      end
      if (c >= 3000) begin
         total++; bad++;
         $display("FAIL %s drain: got timeout want empty fifo", name);
      end
      while ((which == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0)) begin
         e = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
         if ((which == 0) ? (act_a.size() == 0) : (act_b.size() == 0)) begin
            total++; bad++;
            $display("FAIL %s missing: got none want {fid=%0d start=%0d len=%0d last=%0d}",
                     name, e.frame_id, e.start_bin, e.run_len, e.last);
         end else begin
            g = (which == 0) ? act_a.pop_front() : act_b.pop_front();
            cmp_rec(name, g, e);
         end
      end
      cmp_int({name, " extra"}, (which == 0) ? act_a.size() : act_b.size(), 0);
      if (which == 0) act_a.delete(); else act_b.delete();
      @(posedge clk); #1;
   endtask

   // ---------------- drivers ----------------
   task automatic send_beat(input int which, input bit flag, input bit last);
      int c;
      bit acc;
      logic [6:0] junk;
      junk = 7'($urandom);
      if (which == 0) begin
         a_s_tvalid = 1'b1; a_s_tdata = {junk, flag}; a_s_tlast = last;
         if (rand_rdy) begin
            a_m_tready = 1'($urandom_range(0, 1));
            a_min_run  = 12'($urandom_range(0, 4));
         end
      end else begin
         b_s_tvalid = 1'b1; b_s_tdata = {junk, flag}; b_s_tlast = last;
      end
      c = 0;
      acc = 1'b0;
      while (c < 500) begin
         @(negedge clk);
         if ((which == 0 && a_s_tready) || (which == 1 && b_s_tready)) begin acc = 1'b1; break; end
         c++;
         @(posedge clk); #1;
         if (rand_rdy && which == 0) a_m_tready = 1'($urandom_range(0, 1));
      end
      if (!acc) begin
         total++; bad++;
         $display("FAIL beat accept: got timeout want s_tready");
      end
      @(posedge clk); #1;
      if (which == 0) begin a_s_tvalid = 1'b0; a_s_tlast = 1'b0; end
      else begin b_s_tvalid = 1'b0; b_s_tlast = 1'b0; end
   endtask

   task automatic send_frame(input int which, input int n, input logic [63:0] flags, input bit gaps);
      for (int i = 0; i < n; i++) begin
         send_beat(which, flags[i], i == n - 1);
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      string       name;
      int          nbins;
      logic [63:0] flags;
      int          mn;
      int          n_exp;
      report_rec_t e0;
      report_rec_t e1;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int acc_cnt;
      bit saw_stall;
      bit flag;
      logic [63:0] fl;
      int n, p;

      a_s_tvalid = 1'b0; a_s_tdata = '0; a_s_tlast = 1'b0; a_m_tready = 1'b0; a_min_run = '0;
      b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tlast = 1'b0; b_m_tready = 1'b0; b_min_run = '0;

      // bit i of flags is bin i
      vecs[0] = '{"min2_frame",  8, 64'h4E,   2, 2, mk_rec(0, 0, 1, 3), mk_rec(1, 0, 8, 0)};
      vecs[1] = '{"tlast_close", 4, 64'hF,    1, 2, mk_rec(0, 1, 0, 4), mk_rec(1, 1, 4, 0)};
      vecs[2] = '{"all_zero",   16, 64'h0,    1, 1, mk_rec(1, 2, 16, 0), mk_rec(0, 0, 0, 0)};
      vecs[3] = '{"one_bin",     1, 64'h1,    1, 2, mk_rec(0, 3, 0, 1), mk_rec(1, 3, 1, 0)};
      vecs[4] = '{"min0_as_1",   3, 64'h2,    0, 2, mk_rec(0, 4, 1, 1), mk_rec(1, 4, 3, 0)};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      cmp_int("rst m_tvalid", a_m_tvalid, 0);
      cmp_int("rst m_tdata", a_m_tdata, 0);
      cmp_int("rst m_tlast", a_m_tlast, 0);
      cmp_int("rst s_tready", a_s_tready, 0);
      cmp_int("rst b s_tready", b_s_tready, 0);
      cmp_int("rst frame_cnt", a_frame_cnt, 0);
      cmp_int("rst bin_ovf", a_bin_ovf, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cmp_int("ready after reset", a_s_tready, 1);

      // table-driven frames
      for (int v = 0; v < 5; v++) begin
         a_min_run = 12'(vecs[v].mn);
         a_m_tready = 1'b1;
         send_frame(0, vecs[v].nbins, vecs[v].flags, 1'b0);
         exp_a.delete();
         exp_a.push_back(vecs[v].e0);
         if (vecs[v].n_exp > 1) exp_a.push_back(vecs[v].e1);
         check_queue(0, vecs[v].name);
         cmp_int({vecs[v].name, " frame_cnt"}, a_frame_cnt, v + 1);
      end

      // randomized frames with random backpressure and min_run changes
      rand_rdy = 1'b1;
      for (int f = 0; f < 12; f++) begin
         n = $urandom_range(1, 40);
         p = $urandom_range(10, 90);
         fl = '0;
         for (int i = 0; i < n; i++) fl[i] = ($urandom_range(0, 99) < p);
         send_frame(0, n, fl, 1'b1);
      end
      rand_rdy = 1'b0;
      check_queue(0, "random");
      cmp_int("random frame_cnt", a_frame_cnt, fid_a);

      // sustained backpressure with alternating flags
      a_m_tready = 1'b0;
      a_min_run = 12'd1;
      acc_cnt = 0;
      saw_stall = 1'b0;
      flag = 1'b1;
      for (int c = 0; c < 50; c++) begin
         a_s_tvalid = 1'b1; a_s_tdata = {7'd0, flag}; a_s_tlast = 1'b0;
         @(negedge clk);
         if (a_s_tready) begin acc_cnt++; flag = ~flag; end
         else saw_stall = 1'b1;
         @(posedge clk); #1;
      end
      a_s_tvalid = 1'b0;
      @(negedge clk);
      cmp_int("stall seen", saw_stall, 1);
      cmp_int("stall accepted beats", acc_cnt, 14);
      cmp_int("stall s_tready", a_s_tready, 0);
      cmp_int("stall m_tvalid", a_m_tvalid, 1);
      @(posedge clk); #1;
      a_m_tready = 1'b1;
      send_beat(0, 1'b0, 1'b1);
      check_queue(0, "backpressure");

      // narrow instance: bin wrap and run length saturation
      b_min_run = 4'd1;
      b_m_tready = 1'b1;
      send_frame(1, 20, 64'hFFFFF, 1'b0);
      exp_b.delete();
      exp_b.push_back(mk_rec(0, 0, 0, 15));
      exp_b.push_back(mk_rec(1, 0, 4, 0));
      check_queue(1, "ovf_frame");
      cmp_int("b bin_ovf", b_bin_ovf, 1);
      cmp_int("a bin_ovf", a_bin_ovf, 0);

      // reset mid-run with three reports queued
      a_m_tready = 1'b0;
      a_min_run = 12'd1;
      send_beat(0, 1'b1, 1'b0); send_beat(0, 1'b0, 1'b0);
      send_beat(0, 1'b1, 1'b0); send_beat(0, 1'b0, 1'b0);
      send_beat(0, 1'b1, 1'b0); send_beat(0, 1'b0, 1'b0);
      send_beat(0, 1'b1, 1'b0);
      @(negedge clk);
      cmp_int("pre-reset m_tvalid", a_m_tvalid, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      cmp_int("mid rst m_tvalid", a_m_tvalid, 0);
      cmp_int("mid rst m_tdata", a_m_tdata, 0);
      cmp_int("mid rst s_tready", a_s_tready, 0);
      repeat (2) @(posedge clk);
      #1;
      cmp_int("mid rst frame_cnt", a_frame_cnt, 0);
      cmp_int("mid rst b bin_ovf", b_bin_ovf, 0);
      exp_a.delete(); act_a.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      a_m_tready = 1'b1;
      send_frame(0, 4, 64'h6, 1'b0);
      exp_a.delete();
      exp_a.push_back(mk_rec(0, 0, 1, 2));
      exp_a.push_back(mk_rec(1, 0, 4, 0));
      check_queue(0, "after_reset");
      cmp_int("after_reset frame_cnt", a_frame_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
